// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// Define MDU_MADD_EN to implement MADD (MDOp 6) and MSUB (MDOp 7); otherwise they are ignored.
module md_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  MDOp,
  input  logic        start,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);
  localparam int unsigned CntW  = 5;
  localparam int unsigned DataW = 32;

  typedef enum logic {IDLE, RUN} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [DataW-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [DataW-1:0] res_hi_q, res_hi_d, res_lo_q, res_lo_d;
  logic             wr_q, wr_d;
  logic             busy_q, busy_d;

  logic [63:0]      prod_s, prod_u;
  logic [DataW-1:0] div_b, abs_a, abs_b, uq, ur, sq_mag, sr_mag, sq, sr;

  // Full result is computed at the start edge; the counter only models latency.
  // Divisor forced to 1 on B == 0 so the dividers never see zero (result is discarded).
  always_comb begin
    prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    prod_u = {32'd0, A} * {32'd0, B};
    div_b  = (B == '0) ? 32'd1 : B;
    uq     = A / div_b;
    ur     = A % div_b;
    abs_a  = A[31] ? -A : A;
    abs_b  = div_b[31] ? -div_b : div_b;
    sq_mag = abs_a / abs_b;
    sr_mag = abs_a % abs_b;
    sq     = (A[31] ^ div_b[31]) ? -sq_mag : sq_mag;
    sr     = A[31] ? -sr_mag : sr_mag;
  end

`ifdef MDU_MADD_EN
  logic [63:0] acc_add, acc_sub;
  assign acc_add = {hi_q, lo_q} + prod_s;
  assign acc_sub = {hi_q, lo_q} - prod_s;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    wr_d     = wr_q;
    busy_d   = busy_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          unique case (MDOp)
            3'd0, 3'd1: begin
              {res_hi_d, res_lo_d} = (MDOp == 3'd0) ? prod_s : prod_u;
              wr_d    = 1'b1;
              cnt_d   = CntW'(MULT_CYCLES);
              state_d = RUN;
              busy_d  = 1'b1;
            end
            3'd2, 3'd3: begin
              res_hi_d = (MDOp == 3'd2) ? sr : ur;
              res_lo_d = (MDOp == 3'd2) ? sq : uq;
              wr_d     = (B != '0);
              cnt_d    = CntW'(DIV_CYCLES);
              state_d  = RUN;
              busy_d   = 1'b1;
            end
            3'd4: hi_d = A;
            3'd5: lo_d = A;
`ifdef MDU_MADD_EN
            3'd6, 3'd7: begin
              {res_hi_d, res_lo_d} = (MDOp == 3'd6) ? acc_add : acc_sub;
              wr_d    = 1'b1;
              cnt_d   = CntW'(MULT_CYCLES);
              state_d = RUN;
              busy_d  = 1'b1;
            end
`endif
            default: ;
          endcase
        end
      end
      RUN: begin
        if (cnt_q == CntW'(1)) begin
          if (wr_q) begin
            hi_d = res_hi_q;
            lo_d = res_lo_q;
          end
          cnt_d   = '0;
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
      wr_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      wr_q     <= wr_d;
      busy_q   <= busy_d;
    end
  end

  assign busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;
endmodule

// File: tb/tb_md_unit.sv
// Testbench for md_unit: directed vector table, multi-cycle corner sequences, randomized ops vs. model.
module tb_md_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] A, B;
  logic [2:0]  MDOp;
  logic        start;
  logic        busy;
  logic [31:0] HI, LO;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .MDOp(MDOp),
    .start(start), .busy(busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  logic [31:0] hi_m, lo_m;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, eh, el;
    int          cyc;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    MDOp = op; A = a; B = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Issue one op, check HI/LO hold the old state while busy, then latency and final value.
  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                        input int ecyc);
    int n;
    logic [31:0] oh, ol;
    oh = hi_m; ol = lo_m; n = 0;
    issue(op, a, b);
    if (ecyc > 0) begin
      check({name, " mid HI"}, HI, oh);
      check({name, " mid LO"}, LO, ol);
    end
    while (busy === 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, " cycles"}, 32'(n), 32'(ecyc));
    check({name, " HI"}, HI, eh);
    check({name, " LO"}, LO, el);
    hi_m = eh; lo_m = el;
  endtask

  task automatic model_step(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] eh, output logic [31:0] el, output int cyc);
    longint sa, sb;
    longint unsigned ua, ub, acc;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ua = 64'(a); ub = 64'(b);
    eh = hi_m; el = lo_m; cyc = 0;
    case (op)
      3'd0: begin acc = 64'(sa * sb); {eh, el} = acc; cyc = 5; end
      3'd1: begin acc = ua * ub; {eh, el} = acc; cyc = 5; end
      3'd2: begin cyc = 10; if (b != 0) begin el = 32'(sa / sb); eh = 32'(sa % sb); end end
      3'd3: begin cyc = 10; if (b != 0) begin el = 32'(ua / ub); eh = 32'(ua % ub); end end
      3'd4: eh = a;
      3'd5: el = a;
      default: begin
`ifdef MDU_MADD_EN
        acc = {hi_m, lo_m};
        acc = (op == 3'd6) ? acc + 64'(sa * sb) : acc - 64'(sa * sb);
        {eh, el} = acc;
        cyc = 5;
`endif
      end
    endcase
  endtask

  initial begin
    vec_t v[8];
    logic [31:0] eh, el, a, b;
    logic [2:0]  op;
    int          cyc;

    rst_n = 1'b0; start = 1'b0; A = '0; B = '0; MDOp = '0;
    hi_m = '0; lo_m = '0;
    #12;
    check("reset busy", 32'(busy), 32'd0);
    check("reset HI", HI, 32'd0);
    check("reset LO", LO, 32'd0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    v[0] = '{3'd0, 32'hFFFFFFFE, 32'd3,          32'hFFFFFFFF, 32'hFFFFFFFA, 5};
    v[1] = '{3'd1, 32'hFFFFFFFE, 32'd3,          32'h00000002, 32'hFFFFFFFA, 5};
    v[2] = '{3'd2, 32'hFFFFFFF9, 32'd2,          32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    v[3] = '{3'd3, 32'd7,        32'd2,          32'd1,        32'd3,        10};
    v[4] = '{3'd4, 32'h1234,     32'd0,          32'h1234,     32'd3,        0};
    v[5] = '{3'd5, 32'h5678,     32'd0,          32'h1234,     32'h5678,     0};
    v[6] = '{3'd2, 32'd99,       32'd0,          32'h1234,     32'h5678,     10};
    v[7] = '{3'd2, 32'h80000000, 32'hFFFFFFFF,   32'd0,        32'h80000000, 10};
    for (int i = 0; i < 8; i++)
      run_op($sformatf("vec%0d", i), v[i].op, v[i].a, v[i].b, v[i].eh, v[i].el, v[i].cyc);

    // start while busy, and start on the edge busy falls, are both ignored
    issue(3'd0, 32'd6, 32'd7);
    @(posedge clk); #1;
    MDOp = 3'd3; A = 32'd100; B = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy-start busy", 32'(busy), 32'd1);
    @(posedge clk); @(posedge clk); #1;
    MDOp = 3'd5; A = 32'hAA; start = 1'b1;
    @(posedge clk); #1;
    check("fall busy", 32'(busy), 32'd0);
    check("fall HI", HI, 32'd0);
    check("fall LO", LO, 32'd42);
    @(posedge clk); #1;
    start = 1'b0;
    check("mtlo late LO", LO, 32'hAA);
    check("mtlo late busy", 32'(busy), 32'd0);
    hi_m = 32'd0; lo_m = 32'hAA;

    // asynchronous reset mid-DIV drops the pending result
    issue(3'd2, 32'd100, 32'd7);
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("arst busy", 32'(busy), 32'd0);
    check("arst HI", HI, 32'd0);
    check("arst LO", LO, 32'd0);
    #2 rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("post-arst busy", 32'(busy), 32'd0);
    check("post-arst HI", HI, 32'd0);
    check("post-arst LO", LO, 32'd0);
    hi_m = '0; lo_m = '0;

    run_op("mthi0", 3'd4, 32'd0, 32'd0, 32'd0, lo_m, 0);
    run_op("mtlo10", 3'd5, 32'd10, 32'd0, 32'd0, 32'd10, 0);
`ifdef MDU_MADD_EN
    run_op("madd", 3'd6, 32'd3, 32'd4, 32'd0, 32'd22, 5);
    run_op("msub", 3'd7, 32'd5, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFD, 5);
`else
    run_op("madd", 3'd6, 32'd3, 32'd4, 32'd0, 32'd10, 0);
    run_op("msub", 3'd7, 32'd5, 32'd5, 32'd0, 32'd10, 0);
`endif

    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 9));
        2:       b = 32'hFFFFFFFF;
        default: b = $urandom;
      endcase
      model_step(op, a, b, eh, el, cyc);
      run_op($sformatf("rnd%0d op%0d", i, op), op, a, b, eh, el, cyc);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/md_unit.md
# md_unit

Multi-cycle multiply/divide unit in the EX stage, beside the ALU. Takes the same two 32-bit operands, runs signed/unsigned multiply and divide over several cycles, and holds results in the architectural HI/LO registers. `busy` drives the hazard unit so later HI/LO accesses stall until the operation retires. MTHI/MTLO writes finish in one cycle.

## Interface
Parameters:
- `MULT_CYCLES`, 5: busy cycles for MULT/MULTU (and MADD/MSUB); legal range 1..31.
- `DIV_CYCLES`, 10: busy cycles for DIV/DIVU; legal range 1..31.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `A`  in  32  operand rs (dividend / multiplicand / MTHI-MTLO source).
- `B`  in  32  operand rt (divisor / multiplier).
- `MDOp`  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MSUB.
- `start`  in  1  one-cycle request; `MDOp`, `A` and `B` are sampled on the same edge.
- `busy`  out  1  high while an operation is in flight.
- `HI`  out  32  HI register.
- `LO`  out  32  LO register.

## Operation
State machine:
- IDLE
  - `start` with `MDOp` 0..3 (or 6/7 when enabled): latch the operands, load the counter with N, compute the result into internal `res_hi`/`res_lo`, go to RUN.
  - `start` with `MDOp` 4: write `HI` = `A` on that edge; stay IDLE.
  - `start` with `MDOp` 5: write `LO` = `A` on that edge; stay IDLE.
- RUN
  - The counter decrements each cycle.
  - When the counter reaches 1: the next edge writes `res_hi`/`res_lo` into `HI`/`LO` and returns to IDLE.

Arithmetic:
- MULT: 64-bit signed product {HI,LO} = $signed(A)*$signed(B).
- MULTU: 64-bit unsigned product.
- DIV: LO = signed quotient truncated toward zero; HI = remainder, which takes the sign of the dividend.
- DIVU: unsigned quotient in LO, unsigned remainder in HI.
- Signed overflow case 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- Divide by zero (B = 0, DIV or DIVU): `busy` still runs DIV_CYCLES; HI and LO keep their old values.
- MADD/MSUB: {HI,LO} ± signed 64-bit product, computed modulo 2^64 against HI/LO as they stand at the start edge.

Boundaries:
- `start` while `busy`: ignored. No state change; the in-flight result is unaffected.
- Invalid `MDOp` (6/7 without the macro): ignored; no busy, no write.
- `rst_n` low at any time, including mid-RUN: immediately IDLE, counter cleared, the pending result dropped.

## Timing
Reset values:
- `busy` = 0, `HI` = 0, `LO` = 0, state IDLE.

Latency (start sampled at edge E0):
- `busy` = 1 from after E0 until edge E0+N.
- At edge E0+N, `busy` falls and `HI`/`LO` update together.
- N is MULT_CYCLES or DIV_CYCLES, depending on `MDOp`.
- A new `start` is accepted at edge E0+N+1 at the earliest. A `start` on edge E0+N itself is ignored, because `busy` is still 1 when that edge samples it.

Other timing rules:
- MTHI/MTLO: zero busy cycles. The written value appears on `HI`/`LO` right after E0.
- `HI`/`LO` are registered outputs and never show intermediate results.

## Configuration
- `MDU_MADD_EN` defined: MDOp 6 (MADD) and 7 (MSUB) are implemented. Each takes MULT_CYCLES, and HI/LO are read as the accumulator at the start edge.
- `MDU_MADD_EN` undefined: MDOp 6/7 are treated as invalid (ignored); no accumulate datapath is synthesised.

## Test plan
- Reset, then MULT with A=0xFFFFFFFE (-2), B=3 -> `busy` high 5 cycles; afterwards HI=0xFFFFFFFF, LO=0xFFFFFFFA. Repeat as MULTU -> HI=0x00000002, LO=0xFFFFFFFA.
- DIV with A=0xFFFFFFF9 (-7), B=2 -> after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU with A=7, B=2 -> LO=3, HI=1.
- Load HI=0x1234 and LO=0x5678 via MTHI/MTLO (each `busy`=0, visible next cycle). Then DIV with B=0 -> `busy` runs 10 cycles; HI=0x1234, LO=0x5678 unchanged. Then DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- MULT 6*7; at cycle 2 of busy, issue `start` with DIVU 100/3 -> second request ignored; final LO=42, HI=0. On the edge where `busy` falls, `start` with MTLO A=0xAA is also ignored; the same MTLO issued one cycle later writes LO=0xAA.
- Mid-DIV, pulse `rst_n` low asynchronously (between edges) -> `busy`, HI, LO become 0 immediately; no result write after `rst_n` releases.
- With `MDU_MADD_EN`: HI=0, LO=10, then MADD 3*4 -> LO=22. Then MSUB 5*5 -> HI=0xFFFFFFFF, LO=0xFFFFFFFD. Without the macro, the same MADD leaves LO=10 and `busy`=0.
